// File: rtl/find_first_one_index_sequencer_if.sv
// ============================================================================
// Module  : find_first_one_index_sequencer_if
// Brief   : Vector-in / index-out handshake bundle for the first-one sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface find_first_one_index_sequencer_if #(
    parameter int VECTOR_LENGTH    = 8,
    parameter int MAX_OUTPUT_WIDTH = 32
);
    logic [VECTOR_LENGTH-1:0]    vector_in;
    logic                        mode_in;
    logic                        vector_valid_in;
    logic                        vector_ready_out;
    logic [MAX_OUTPUT_WIDTH-1:0] index_out;
    logic                        index_valid_out;
    logic                        index_ready_in;
    logic                        last_out;
    logic                        done_out;

    // Producer of vectors and consumer of indices.
    modport master (
        output vector_in, mode_in, vector_valid_in, index_ready_in,
        input  vector_ready_out, index_out, index_valid_out, last_out, done_out
    );

    modport slave (
        input  vector_in, mode_in, vector_valid_in, index_ready_in,
        output vector_ready_out, index_out, index_valid_out, last_out, done_out
    );
endinterface

`default_nettype wire

// File: rtl/find_first_one_index_sequencer.sv
// ============================================================================
// Module  : find_first_one_index_sequencer
// Brief   : Drains a request bitmap one set-bit index per handshake, with
//           fixed LSB-first or round-robin priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module find_first_one_index_sequencer #(
    parameter int VECTOR_LENGTH    = 8,
    parameter int MAX_OUTPUT_WIDTH = 32
) (
    input  wire logic clk_in,
    input  wire logic reset_in,
    find_first_one_index_sequencer_if.slave bus
);
    localparam int c_idx_w = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(VECTOR_LENGTH - 1);
    localparam logic [VECTOR_LENGTH-1:0] c_one = VECTOR_LENGTH'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                   r_state, w_state_next;
    logic [VECTOR_LENGTH-1:0] r_pending, w_pending_next;
    logic                     r_mode, w_mode_next;
    logic [c_idx_w-1:0]       r_rr_ptr, w_rr_next;
    logic [c_idx_w-1:0]       r_idx, w_idx_next;
    logic                     r_valid, w_valid_next;
    logic                     r_last, w_last_next;
    logic                     r_done, w_done_next;

    logic [VECTOR_LENGTH-1:0] w_cleared;
    logic [c_idx_w-1:0]       w_rr_adv;
    logic [VECTOR_LENGTH-1:0] w_src_vec;
    logic                     w_src_mode;
    logic [c_idx_w-1:0]       w_src_ptr;
    logic [c_idx_w-1:0]       w_pick;
    logic                     w_src_last;

    // First set bit at or above the start point, wrapping; start is 0 in mode 0.
    function automatic logic [c_idx_w-1:0] pick_first(
        input logic [VECTOR_LENGTH-1:0] vec,
        input logic                     mode,
        input logic [c_idx_w-1:0]       ptr
    );
        logic [c_idx_w:0]   j;
        logic [c_idx_w-1:0] start;
        logic               found;
        pick_first = '0;
        found      = 1'b0;
        start      = mode ? ptr : '0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            j = {1'b0, start} + (c_idx_w+1)'(i);
            if (j >= (c_idx_w+1)'(VECTOR_LENGTH)) begin
                j = j - (c_idx_w+1)'(VECTOR_LENGTH);
            end
            if (!found && vec[j[c_idx_w-1:0]]) begin
                found      = 1'b1;
                pick_first = j[c_idx_w-1:0];
            end
        end
    endfunction

    assign w_cleared = r_pending & ~(c_one << r_idx);
    assign w_rr_adv  = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    // The search runs on the incoming vector in IDLE, and on the post-accept
    // bitmap and pointer in ISSUE, so one search unit serves both.
    always_comb begin
        w_src_vec  = bus.vector_in;
        w_src_mode = bus.mode_in;
        w_src_ptr  = r_rr_ptr;
        if (r_state == ISSUE) begin
            w_src_vec  = w_cleared;
            w_src_mode = r_mode;
            w_src_ptr  = r_mode ? w_rr_adv : r_rr_ptr;
        end
    end

    assign w_pick     = pick_first(w_src_vec, w_src_mode, w_src_ptr);
    assign w_src_last = (w_src_vec != '0) && ((w_src_vec & (w_src_vec - 1'b1)) == '0);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_mode    <= 1'b0;
            r_rr_ptr  <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_mode    <= w_mode_next;
            r_rr_ptr  <= w_rr_next;
            r_idx     <= w_idx_next;
            r_valid   <= w_valid_next;
            r_last    <= w_last_next;
            r_done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_mode_next    = r_mode;
        w_rr_next      = r_rr_ptr;
        w_idx_next     = r_idx;
        w_valid_next   = r_valid;
        w_last_next    = r_last;
        w_done_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.vector_valid_in) begin
                    w_pending_next = bus.vector_in;
                    w_mode_next    = bus.mode_in;
                    if (bus.vector_in == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_idx_next   = w_pick;
                        w_last_next  = w_src_last;
                        w_valid_next = 1'b1;
                        w_state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.index_ready_in) begin
                    w_pending_next = w_cleared;
                    if (r_mode) begin
                        w_rr_next = w_rr_adv;
                    end
                    if (w_cleared != '0) begin
                        w_idx_next  = w_pick;
                        w_last_next = w_src_last;
                    end else begin
                        w_valid_next = 1'b0;
                        w_last_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.vector_ready_out = (r_state == IDLE);
    assign bus.index_out        = MAX_OUTPUT_WIDTH'(r_idx);
    assign bus.index_valid_out  = r_valid;
    assign bus.last_out         = r_last;
    assign bus.done_out         = r_done;

endmodule

`default_nettype wire

// File: doc/find_first_one_index_sequencer.md
# find_first_one_index_sequencer

Sequential successor to the combinational first-one finder. Accepts a VECTOR_LENGTH-bit request vector over a valid/ready handshake. Emits the index of every set bit, one per handshake, on a valid/ready output stream. Supports fixed LSB-first priority or round-robin priority that resumes after the last issued index. Used by arbiters and issue logic that must drain a bitmap of pending requests.

## Interface
- VECTOR_LENGTH, 8, width of the request vector; at least 2.
- MAX_OUTPUT_WIDTH, 32, width of index_out; at least clog2(VECTOR_LENGTH).
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  reset, asynchronous, active-low.
- vector_in  input  VECTOR_LENGTH  request bitmap; bit i set means index i is pending.
- mode_in  input  1  0 = fixed priority from bit 0 upward; 1 = round-robin; sampled with vector_in.
- vector_valid_in  input  1  vector_in and mode_in are valid.
- vector_ready_out  output  1  block can accept a vector; high only in IDLE.
- index_out  output  MAX_OUTPUT_WIDTH  current index, zero-extended.
- index_valid_out  output  1  index_out is valid.
- index_ready_in  input  1  consumer accepts index_out.
- last_out  output  1  index_out is the final set bit of the current vector; qualified by index_valid_out.
- done_out  output  1  one-cycle pulse when a vector has been fully drained, including an all-zero vector.

## Operation
- State machine:
  - IDLE: vector_ready_out=1.
    - On vector_valid_in & vector_ready_out, latch vector_in into pending and latch mode_in.
    - If vector_in is zero, assert done_out the next cycle and stay in IDLE.
    - Otherwise, register the first index and last flag, then go to ISSUE.
  - ISSUE: index_valid_out=1.
    - On index_valid_out & index_ready_in, clear that bit in pending.
    - If bits remain, register the next index and last flag and stay in ISSUE.
    - Otherwise, go to IDLE and pulse done_out.
- Search order:
  - Mode 0: the lowest set bit of pending.
  - Mode 1: the first set bit at or above rr_ptr, wrapping from VECTOR_LENGTH-1 to 0.
- rr_ptr:
  - VECTOR_LENGTH-bit-index register, reset 0.
  - Updated only on accepted mode-1 indices, to (index+1) mod VECTOR_LENGTH.
  - Persists across vectors; mode-0 vectors leave it unchanged.
- last_out is high when pending has exactly one bit set.
- index_out, last_out and index_valid_out are registered and hold stable while index_valid_out & ~index_ready_in.
- Inputs on vector_in are ignored outside IDLE; the upstream source must hold them under its own valid.
- Reset values:
  - State IDLE, pending 0, rr_ptr 0.
  - index_out 0, index_valid_out 0, last_out 0, done_out 0.
  - vector_ready_out 1 once reset_in is deasserted.
- Reset mid-ISSUE: pending and rr_ptr are lost immediately, all outputs go to reset values asynchronously, and no done_out is emitted.

## Timing
- Vector accepted at edge N: the first index_valid_out is high in the cycle after edge N.
- Throughput: one index per cycle while index_ready_in is held high. A vector with K set bits drains in K cycles.
- Final index accepted at edge M: done_out=1 and vector_ready_out=1 in the cycle after edge M. done_out drops at edge M+1.
- A new vector can be accepted in that same done_out cycle, giving a one-cycle bubble between vectors.
- Zero vector accepted at edge N: done_out is high for one cycle after edge N, and index_valid_out stays 0.
- No combinational path from index_ready_in or vector_valid_in to any output.

## Test plan
- Reset:
  - Stimulus: assert reset_in=0 with random inputs, then deassert.
  - Required: all outputs at reset values; vector_ready_out=1 after deassert.
- Mode 0 drain:
  - Stimulus: vector 8'b1010_0100, index_ready_in=1.
  - Required: indices 2, 5, 7 on consecutive cycles; last_out only with 7; done_out one cycle later.
- Back-pressure:
  - Stimulus: same vector, index_ready_in low for 3 cycles while index 5 is presented.
  - Required: index_out=5 and index_valid_out=1 stable for all 3 cycles, then the sequence continues with 7.
- Empty vector:
  - Stimulus: vector 8'h00.
  - Required: no index_valid_out; done_out pulses for exactly one cycle; vector_ready_out stays 1.
- Round-robin:
  - Stimulus: mode 1, vector 8'h10, then 8'h21.
  - Required: first vector yields 4 and rr_ptr=5; second vector yields 5, then 0 with last_out; rr_ptr=1.
  - Stimulus: mode 0, vector 8'hFF.
  - Required: indices 0..7 in 8 consecutive cycles; rr_ptr stays 1.
- Reset mid-operation:
  - Stimulus: vector 8'hF0, assert reset_in=0 after index 5 is accepted.
  - Required: index_valid_out drops at once and no done_out.
  - Stimulus: after release, vector 8'h03.
  - Required: indices 0, 1, done_out.
